phivers_plic: RTL and testbench
===============================

Name: phivers_plic

Overview:
- Memory-mapped platform interrupt controller feeding the RS5 core's machine external interrupt (mei) line inside each Phivers PE.
- Collects the interrupt sources (DMNI first, future peripherals after), applies enable masking and fixed priority, and runs a single-outstanding claim/complete handshake.
- CPU access goes through the PE data bus window at 0x02000000; read data is valid the cycle after the access.

Parameters:
- I_CNT, 1, number of interrupt sources (1..31); source n has ID n+1, and ID 0 means "none".

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  bus select for this window
- we_i  in  4  byte write enables; any nonzero value is a write, else a read
- addr_i  in  32  bus address; only [3:2] are decoded
- data_i  in  32  write data
- data_o  out  32  registered read data
- irq_i  in  I_CNT  interrupt source lines, level-high
- iack_i  in  1  core interrupt-taken pulse
- iack_o  out  1  one-cycle pulse acknowledging a latched claim
- irq_o  out  1  external interrupt request to the core

Behaviour:
- Reset: all registers clear, data_o=0, irq_o=0, iack_o=0, FSM=IDLE.
- Register map:
  - 0x0 PENDING (read-only; writes ignored).
  - 0x4 ENABLE (RW; bits >= I_CNT read 0).
  - 0x8 CLAIM/COMPLETE.
  - 0xC MODE (see optional feature).
- Gateway (level mode): pending[n] is set when irq_i[n]=1 and source n is not the claimed source. Pending is set regardless of enable.
- Priority: lowest index among (pending & enable) wins; best_id = winner index + 1, or 0 if none.
- FSM:
  - IDLE: if best_id != 0, go to REQ.
  - REQ: irq_o=1. If best_id drops to 0 (enable cleared), return to IDLE.
    - On iack_i: latch claim_id=best_id, go to CLAIMED, pulse iack_o=1 the next cycle.
    - A CLAIM read while in REQ takes the same path but without the iack_o pulse, and goes directly to SERVICE.
  - CLAIMED: irq_o=0. A CLAIM read returns claim_id, clears pending[claim_id-1], and goes to SERVICE.
  - SERVICE: irq_o=0. A write to 0x8 with data_i[4:0]==claim_id goes to IDLE and clears claim_id. A write with a mismatched ID is ignored.
- CLAIM read outside REQ/CLAIMED returns 0 with no side effect. In SERVICE, a read returns 0 as well.
- Read timing: data_o is registered one cycle after en_i with we_i==0; it holds its value otherwise.
- Simultaneous events:
  - Same-cycle iack_i and CLAIM read in REQ: iack path wins, then the read is treated as in CLAIMED.
  - Pending set and claim-clear of the same bit in the same cycle: clear wins.
- A higher-priority source arriving during CLAIMED/SERVICE stays pending and is presented after completion (no nesting).
- Reset asserted mid-claim: immediate return to the reset state; there is no residual in-service source.

Optional Feature:
- Macro: PLIC_EDGE_EN.
- With PLIC_EDGE_EN defined:
  - MODE register at 0xC is RW; bit n=1 makes source n edge-triggered.
  - For an edge source, the rising edge of irq_i[n] (registered compare) sets pending[n], even while that source is claimed.
  - An edge arriving in the same cycle as the claim-clear wins, because it is a new event.
- Without it: every source is level-triggered, 0xC reads 0, writes to 0xC are ignored, and no edge registers exist.

Test Plan:
- Reset then read 0x0, 0x4, 0x8 -> each returns 0x00000000 one cycle later; irq_o=0 and iack_o=0.
- I_CNT=4, write ENABLE=0xF, drive irq_i=4'b1010 -> PENDING=0xA, irq_o=1 within 2 cycles; pulse iack_i -> iack_o=1 next cycle; CLAIM read=2; irq_o stays 0 until a write of 0x2 to 0x8, then rises again for ID 4.
- ENABLE=0x0 with irq_i[0]=1 -> PENDING=0x1, irq_o=0; write ENABLE=0x1 -> irq_o=1 next cycle.
- In SERVICE with claim_id=1, write COMPLETE=3 -> ignored, still SERVICE and irq_o=0; write 1 -> IDLE.
- Pulse rst_ni low in CLAIMED -> all outputs 0 asynchronously; a CLAIM read after reset returns 0.
- PLIC_EDGE_EN, MODE=0x1, 1-cycle irq_i[0] pulse -> PENDING=0x1 latched after the pulse ends; a second pulse during SERVICE re-pends it, and irq_o=1 after completion.

Source files
------------

// File: rtl/phivers_plic.sv
// Platform interrupt controller driving the RS5 machine external interrupt line.
// Optional edge-triggered sources are enabled with the PLIC_EDGE_EN macro.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | no request presented; waiting for an enabled pending source
//  ST_REQ     | irq_o high; waiting for iack_i or a CLAIM read
//  ST_CLAIMED | core took the interrupt; claim_id latched, waiting CLAIM read
//  ST_SERVICE | handler running; waiting COMPLETE write of claim_id
module phivers_plic #(
    parameter int I_CNT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [I_CNT-1:0] irq_i,
    input  logic             iack_i,
    output logic             iack_o,
    output logic             irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CLAIMED,
        ST_SERVICE
    } state_t;

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_EN    = 2'd1;
    localparam logic [1:0] A_CLAIM = 2'd2;
    localparam logic [1:0] A_MODE  = 2'd3;

    state_t           state_q, state_d;
    logic [I_CNT-1:0] pending_q, pending_d;
    logic [I_CNT-1:0] enable_q;
    logic [4:0]       claim_id_q, claim_id_d;
    logic [31:0]      data_q;
    logic             iack_q, iack_d;

    logic             bus_rd, bus_wr;
    logic             claim_rd, complete_wr;
    logic [4:0]       best_id;
    logic [I_CNT-1:0] active;
    logic [I_CNT-1:0] clr_vec, lvl_set;
    logic             clr_en;
    logic [4:0]       clr_id;
    logic [4:0]       claim_rdata;
    logic [31:0]      rdata;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

    assign bus_rd      = en_i && (we_i == 4'd0);
    assign bus_wr      = en_i && (we_i != 4'd0);
    assign claim_rd    = bus_rd && (addr_i[3:2] == A_CLAIM);
    assign complete_wr = bus_wr && (addr_i[3:2] == A_CLAIM);

    assign active = pending_q & enable_q;

    // Fixed priority: lowest index wins, so scan from the top down.
    always_comb begin
        best_id = '0;
        for (int i = I_CNT - 1; i >= 0; i--) begin
            if (active[i]) best_id = 5'(i + 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        claim_id_d  = claim_id_q;
        iack_d      = 1'b0;
        clr_en      = 1'b0;
        clr_id      = claim_id_q;
        claim_rdata = '0;
        irq_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (best_id != 5'd0) state_d = ST_REQ;
            end
            ST_REQ: begin
                irq_o = 1'b1;
                if (best_id == 5'd0) begin
                    state_d = ST_IDLE;
                end else if (iack_i) begin
                    claim_id_d = best_id;
                    iack_d     = 1'b1;
                    state_d    = ST_CLAIMED;
                    // A same-cycle CLAIM read is served as if already claimed.
                    if (claim_rd) begin
                        claim_rdata = best_id;
                        clr_en      = 1'b1;
                        clr_id      = best_id;
                        state_d     = ST_SERVICE;
                    end
                end else if (claim_rd) begin
                    claim_id_d  = best_id;
                    claim_rdata = best_id;
                    clr_en      = 1'b1;
                    clr_id      = best_id;
                    state_d     = ST_SERVICE;
                end
            end
            ST_CLAIMED: begin
                if (claim_rd) begin
                    claim_rdata = claim_id_q;
                    clr_en      = 1'b1;
                    clr_id      = claim_id_q;
                    state_d     = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (complete_wr && (data_i[4:0] == claim_id_q)) begin
                    claim_id_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_vec = '0;
        lvl_set = '0;
        for (int i = 0; i < I_CNT; i++) begin
            clr_vec[i] = clr_en && (clr_id == 5'(i + 1));
            lvl_set[i] = irq_i[i] && (claim_id_q != 5'(i + 1));
        end
    end

`ifdef PLIC_EDGE_EN
    logic [I_CNT-1:0] mode_q;
    logic [I_CNT-1:0] irq_q;
    logic [I_CNT-1:0] rise;

    assign rise = irq_i & ~irq_q;
    // Edge sources: a new rising edge beats the claim-clear.
    assign pending_d = (mode_q  & (rise | (pending_q & ~clr_vec)))
                     | (~mode_q & ((pending_q | lvl_set) & ~clr_vec));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= '0;
            irq_q  <= '0;
        end else begin
            irq_q <= irq_i;
            if (bus_wr && (addr_i[3:2] == A_MODE)) mode_q <= data_i[I_CNT-1:0];
        end
    end
`else
    assign pending_d = (pending_q | lvl_set) & ~clr_vec;
`endif

    always_comb begin
        rdata = '0;
        case (addr_i[3:2])
            A_PEND:  rdata[I_CNT-1:0] = pending_q;
            A_EN:    rdata[I_CNT-1:0] = enable_q;
            A_CLAIM: rdata[4:0]       = claim_rdata;
            A_MODE: begin
`ifdef PLIC_EDGE_EN
                rdata[I_CNT-1:0] = mode_q;
`else
                rdata = '0;
`endif
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            enable_q   <= '0;
            claim_id_q <= '0;
            data_q     <= '0;
            iack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            claim_id_q <= claim_id_d;
            iack_q     <= iack_d;
            if (bus_wr && (addr_i[3:2] == A_EN)) enable_q <= data_i[I_CNT-1:0];
            if (bus_rd) data_q <= rdata;
        end
    end

    assign data_o = data_q;
    assign iack_o = iack_q;

endmodule

// File: tb/tb_phivers_plic.sv
// Directed self-checking bench for phivers_plic with four sources.
// Edge-mode checks are compiled in when PLIC_EDGE_EN is defined.
module tb_phivers_plic;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  we_i = 4'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [3:0]  irq_i = 4'd0;
    logic        iack_i = 1'b0;
    logic        iack_o;
    logic        irq_o;

    int total = 0;
    int bad = 0;
    logic [31:0] rd;

    phivers_plic #(.I_CNT(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_i  (irq_i),
        .iack_i (iack_i),
        .iack_o (iack_o),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        en_i = 1'b1; we_i = 4'd0; addr_i = a;
        @(posedge clk_i); #1;
        en_i = 1'b0;
        d = data_o;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = v;
        @(posedge clk_i); #1;
        en_i = 1'b0; we_i = 4'd0;
    endtask

    task automatic pulse_iack;
        iack_i = 1'b1;
        @(posedge clk_i); #1;
        iack_i = 1'b0;
    endtask

    initial begin
        // reset state
        #23;
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_iack", {31'd0, iack_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        bus_rd(32'h0200_0000, rd); chk("rst_pend", rd, 32'd0);
        bus_rd(32'h0200_0004, rd); chk("rst_en", rd, 32'd0);
        bus_rd(32'h0200_0008, rd); chk("rst_claim", rd, 32'd0);

        // basic claim/complete with two sources
        bus_wr(32'h0200_0004, 32'hFFFF_FFFF);
        bus_rd(32'h0200_0004, rd); chk("en_mask", rd, 32'h0000_000F);
        bus_wr(32'h0200_0000, 32'h5);
        irq_i = 4'b1010;
        tick(2);
        chk("req_irq", {31'd0, irq_o}, 32'd1);
        bus_rd(32'h0200_0000, rd); chk("pend_a", rd, 32'h0000_000A);
        pulse_iack;
        chk("iack_pulse", {31'd0, iack_o}, 32'd1);
        chk("claimed_irq", {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("iack_once", {31'd0, iack_o}, 32'd0);
        bus_rd(32'h0200_0008, rd); chk("claim_2", rd, 32'd2);
        irq_i = 4'b1000;
        bus_rd(32'h0200_0000, rd); chk("pend_cleared", rd, 32'h0000_0008);
        bus_rd(32'h0200_0008, rd); chk("svc_claim_0", rd, 32'd0);
        tick(2);
        chk("svc_irq", {31'd0, irq_o}, 32'd0);
        bus_wr(32'h0200_0008, 32'd2);
        chk("idle_irq", {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("req4_irq", {31'd0, irq_o}, 32'd1);
        bus_rd(32'h0200_0008, rd); chk("claim_4", rd, 32'd4);
        chk("rd_no_iack", {31'd0, iack_o}, 32'd0);
        chk("rd_svc_irq", {31'd0, irq_o}, 32'd0);
        irq_i = 4'b0000;
        bus_wr(32'h0200_0008, 32'd4);
        tick(2);
        chk("empty_irq", {31'd0, irq_o}, 32'd0);

        // masking: pending regardless of enable
        bus_wr(32'h0200_0004, 32'd0);
        irq_i = 4'b0001;
        tick(2);
        bus_rd(32'h0200_0000, rd); chk("masked_pend", rd, 32'h0000_0001);
        chk("masked_irq", {31'd0, irq_o}, 32'd0);
        bus_wr(32'h0200_0004, 32'd1);
        tick(1);
        chk("unmask_irq", {31'd0, irq_o}, 32'd1);

        // mismatched complete is ignored
        bus_rd(32'h0200_0008, rd); chk("claim_1", rd, 32'd1);
        irq_i = 4'b0000;
        bus_wr(32'h0200_0008, 32'd3);
        bus_wr(32'h0200_0004, 32'hF);
        irq_i = 4'b0100;
        tick(3);
        chk("bad_cmpl_irq", {31'd0, irq_o}, 32'd0);
        bus_rd(32'h0200_0000, rd); chk("pend_during_svc", rd, 32'h0000_0004);
        bus_wr(32'h0200_0008, 32'd1);
        tick(1);
        chk("good_cmpl_irq", {31'd0, irq_o}, 32'd1);

        // same-cycle iack and CLAIM read in REQ
        en_i = 1'b1; we_i = 4'd0; addr_i = 32'h0200_0008; iack_i = 1'b1;
        @(posedge clk_i); #1;
        en_i = 1'b0; iack_i = 1'b0;
        chk("both_data", data_o, 32'd3);
        chk("both_iack", {31'd0, iack_o}, 32'd1);
        irq_i = 4'b0000;
        bus_rd(32'h0200_0008, rd); chk("both_svc", rd, 32'd0);
        bus_wr(32'h0200_0008, 32'd3);
        tick(2);
        chk("both_done_irq", {31'd0, irq_o}, 32'd0);

        // async reset in CLAIMED
        irq_i = 4'b0001;
        tick(2);
        pulse_iack;
        irq_i = 4'b0000;
        chk("pre_rst_iack", {31'd0, iack_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_iack", {31'd0, iack_o}, 32'd0);
        chk("arst_irq", {31'd0, irq_o}, 32'd0);
        chk("arst_data", data_o, 32'd0);
        #1 rst_ni = 1'b1;
        bus_rd(32'h0200_0008, rd); chk("post_rst_claim", rd, 32'd0);
        bus_rd(32'h0200_0004, rd); chk("post_rst_en", rd, 32'd0);

`ifdef PLIC_EDGE_EN
        bus_wr(32'h0200_000C, 32'h1);
        bus_wr(32'h0200_0004, 32'h1);
        bus_rd(32'h0200_000C, rd); chk("mode_rw", rd, 32'h1);
        irq_i = 4'b0001;
        @(posedge clk_i); #1;
        irq_i = 4'b0000;
        bus_rd(32'h0200_0000, rd); chk("edge_pend", rd, 32'h1);
        bus_rd(32'h0200_0008, rd); chk("edge_claim", rd, 32'd1);
        irq_i = 4'b0001;
        @(posedge clk_i); #1;
        irq_i = 4'b0000;
        bus_rd(32'h0200_0000, rd); chk("edge_repend", rd, 32'h1);
        chk("edge_svc_irq", {31'd0, irq_o}, 32'd0);
        bus_wr(32'h0200_0008, 32'd1);
        tick(1);
        chk("edge_after_irq", {31'd0, irq_o}, 32'd1);
`else
        bus_wr(32'h0200_000C, 32'hF);
        bus_rd(32'h0200_000C, rd); chk("mode_ro", rd, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
